// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter.
// The arb_timeout signal exists only when UART_TX_ARB_TIMEOUT_EN is defined.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_byte;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_valid;
    logic [7:0]           tx_byte;
    logic                 tx_busy;
    logic                 arb_idle;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic                 arb_timeout;
`endif

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Arbiter side
    modport slave (
        input  req_valid, req_byte, req_last, tx_busy,
        output req_ready, grant, tx_valid, tx_byte, arb_idle, arb_timeout
    );
    // Producers plus uart_tx side
    modport master (
        output req_valid, req_byte, req_last, tx_busy,
        input  req_ready, grant, tx_valid, tx_byte, arb_idle, arb_timeout
    );
`else
    // Arbiter side
    modport slave (
        input  req_valid, req_byte, req_last, tx_busy,
        output req_ready, grant, tx_valid, tx_byte, arb_idle
    );
    // Producers plus uart_tx side
    modport master (
        output req_valid, req_byte, req_last, tx_busy,
        input  req_ready, grant, tx_valid, tx_byte, arb_idle
    );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart_tx between NUM_REQ
// debug byte streams. A grant covers a whole message (up to req_last), and a
// GAP_CYCLES idle window precedes every byte launch because tx_busy lags
// tx_valid.
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN releases a grant whose owner
// stalls for TIMEOUT_CYCLES and pulses arb_timeout.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned GAP_CYCLES = 15
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_arbiter_if.slave   bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_LAUNCH,
        S_DRAIN
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     g_idx;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 last_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [TO_W-1:0]      stall_cnt;
`endif

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic                 sel_valid;
    logic                 sel_last;
    logic [7:0]           sel_byte;
    logic [IDX_W-1:0]     next_ptr;
    logic                 gap_done;

    // Round-robin pick: first requester at or above rr_ptr, else wrap to the lowest.
    always_comb begin
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (!pick_found && bus.req_valid[j] && (IDX_W'(j) >= rr_ptr)) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(j);
            end
        end
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (!pick_found && bus.req_valid[j]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(j);
            end
        end
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            pick_onehot[j] = (IDX_W'(j) == pick_idx);
        end
    end

    // Lane mux for the current grant owner.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_byte  = 8'h00;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (IDX_W'(j) == g_idx) begin
                sel_valid = bus.req_valid[j];
                sel_last  = bus.req_last[j];
                sel_byte  = bus.req_byte[j*8 +: 8];
            end
        end
    end

    // Pointer just past the owner, and end of the enforced idle window.
    assign next_ptr = (g_idx == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx + IDX_W'(1);
    assign gap_done = (gap_cnt == GAP_W'(GAP_CYCLES));

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            g_idx         <= '0;
            gap_cnt       <= '0;
            last_q        <= 1'b0;
            bus.req_ready <= '0;
            bus.grant     <= '0;
            bus.tx_valid  <= 1'b0;
            bus.tx_byte   <= 8'h00;
            bus.arb_idle  <= 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
            stall_cnt       <= '0;
            bus.arb_timeout <= 1'b0;
`endif
        end else begin
            bus.req_ready <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            bus.arb_timeout <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        bus.grant    <= pick_onehot;
                        g_idx        <= pick_idx;
                        gap_cnt      <= '0;
                        bus.arb_idle <= 1'b0;
                        state        <= S_GAP;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        stall_cnt    <= '0;
`endif
                    end
                end

                S_GAP: begin
                    if (!gap_done) begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end else if (sel_valid && !bus.tx_busy) begin
                        bus.tx_byte   <= sel_byte;
                        bus.tx_valid  <= 1'b1;
                        bus.req_ready <= pick_mask(g_idx);
                        last_q        <= sel_last;
                        state         <= S_LAUNCH;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        stall_cnt     <= '0;
                    end else if (!sel_valid) begin
                        // Owner went quiet mid-message: give the line away eventually.
                        if (stall_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                            stall_cnt       <= '0;
                            bus.grant       <= '0;
                            rr_ptr          <= next_ptr;
                            bus.arb_idle    <= 1'b1;
                            bus.arb_timeout <= 1'b1;
                            state           <= S_IDLE;
                        end else begin
                            stall_cnt <= stall_cnt + TO_W'(1);
                        end
`endif
                    end
                end

                S_LAUNCH: begin
                    if (bus.tx_busy) begin
                        bus.tx_valid <= 1'b0;
                        state        <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (!bus.tx_busy) begin
                        if (last_q) begin
                            bus.grant    <= '0;
                            rr_ptr       <= next_ptr;
                            bus.arb_idle <= 1'b1;
                            state        <= S_IDLE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // One-hot mask for a lane index.
    function automatic logic [NUM_REQ-1:0] pick_mask(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] m;
        m = '0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            m[j] = (IDX_W'(j) == idx);
        end
        return m;
    endfunction

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of per-byte records driven through
// per-lane handshake drivers, plus hand sequences for reset and stall cases.
// Honours UART_TX_ARB_TIMEOUT_EN when defined.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int GAP  = 15;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NREQ),
        .GAP_CYCLES(GAP)
`ifdef UART_TX_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(64)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // uart_tx model: busy rises 2 cycles after tx_valid and stays high 20 cycles.
    bit model_en = 1'b1;
    int m_phase;
    int m_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.tx_busy <= 1'b0;
            m_phase     <= 0;
            m_cnt       <= 0;
        end else begin
            case (m_phase)
                0: if (model_en && bus.tx_valid) m_phase <= 1;
                1: begin
                    bus.tx_busy <= 1'b1;
                    m_cnt       <= 19;
                    m_phase     <= 2;
                end
                default: begin
                    if (m_cnt == 0) begin
                        bus.tx_busy <= 1'b0;
                        m_phase     <= 0;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
            endcase
        end
    end

    typedef struct {
        int         scen;
        int         lane;
        logic [7:0] data;
        logic       last;
        int         pos;    // expected position in the transmitted stream
    } vec_t;

    vec_t vecs[$];

    int n_vec = 0;
    int n_bad = 0;

    logic [8:0]  lane_data [NREQ][16];
    int          lane_len  [NREQ];
    int          lane_pos  [NREQ];
    bit          ready_seen[NREQ];
    int          rdy_cnt   [NREQ];

    logic [15:0] log_rec [32];
    int          n_log;
    int          cyc = 0;
    int          first_valid, first_tx, fall_cyc, min_gap, bad_ready, to_cnt;
    bit          prev_busy, prev_txv, idle_mid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic clear_drivers();
        for (int l = 0; l < NREQ; l++) begin
            lane_len[l]   = 0;
            lane_pos[l]   = 0;
            ready_seen[l] = 1'b0;
            rdy_cnt[l]    = 0;
        end
        for (int k = 0; k < 32; k++) log_rec[k] = '0;
        n_log = 0; first_valid = -1; first_tx = -1; fall_cyc = -1;
        min_gap = 1000; bad_ready = 0; to_cnt = 0; idle_mid = 1'b0;
        prev_busy = 1'b0; prev_txv = 1'b0;
        bus.req_valid = '0;
        bus.req_byte  = '0;
        bus.req_last  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_drivers();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push_lane(input int l, input logic [7:0] d, input logic last);
        lane_data[l][lane_len[l]] = {last, d};
        lane_len[l]++;
    endtask

    // One clock: sample outputs #1 after the edge, then update the lane drivers.
    task automatic step();
        logic [NREQ-1:0]   v, lst;
        logic [NREQ*8-1:0] b;
        @(posedge clk);
        #1;
        cyc++;
        if (|bus.req_ready) begin
            if (n_log < 32) log_rec[n_log] = {bus.grant, bus.req_ready, bus.tx_byte};
            n_log++;
        end
        for (int l = 0; l < NREQ; l++) if (bus.req_ready[l]) rdy_cnt[l]++;
        if ((bus.req_ready & ~bus.grant) != '0) bad_ready++;
        if (prev_busy && !bus.tx_busy) fall_cyc = cyc;
        if (!prev_txv && bus.tx_valid && fall_cyc >= 0 && (cyc - fall_cyc) < min_gap)
            min_gap = cyc - fall_cyc;
        if (bus.tx_valid && first_tx < 0) first_tx = cyc;
        if (n_log == 2 && bus.arb_idle) idle_mid = 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
        if (bus.arb_timeout) to_cnt++;
`endif
        prev_busy = bus.tx_busy;
        prev_txv  = bus.tx_valid;
        v = '0; lst = '0; b = '0;
        for (int l = 0; l < NREQ; l++) begin
            if (ready_seen[l]) lane_pos[l]++;
            ready_seen[l] = bus.req_ready[l];
            if (lane_pos[l] < lane_len[l]) begin
                v[l]         = 1'b1;
                lst[l]       = lane_data[l][lane_pos[l]][8];
                b[l*8 +: 8]  = lane_data[l][lane_pos[l]][7:0];
            end
        end
        if (v != '0 && first_valid < 0) first_valid = cyc;
        bus.req_valid = v;
        bus.req_last  = lst;
        bus.req_byte  = b;
    endtask

    function automatic bit all_done();
        bit d;
        d = bus.arb_idle && !bus.tx_busy;
        for (int l = 0; l < NREQ; l++)
            if (lane_pos[l] != lane_len[l] || ready_seen[l]) d = 1'b0;
        return d;
    endfunction

    // Load a scenario from the table, run it to completion, compare its records.
    task automatic run_scen(input int s, input bit rst_first);
        int  budget;
        int  nexp;
        bit  done;
        logic [3:0] oh;
        if (rst_first) do_reset();
        else clear_drivers();
        nexp = 0;
        foreach (vecs[k]) if (vecs[k].scen == s) begin
            push_lane(vecs[k].lane, vecs[k].data, vecs[k].last);
            nexp++;
        end
        budget = 0;
        done   = 1'b0;
        while (!done && budget < 3000) begin
            step();
            budget++;
            done = all_done();
        end
        check($sformatf("scen%0d_completes", s), 32'(done), 32'd1);
        check($sformatf("scen%0d_byte_count", s), 32'(n_log), 32'(nexp));
        check($sformatf("scen%0d_ready_outside_grant", s), 32'(bad_ready), 32'd0);
        foreach (vecs[k]) if (vecs[k].scen == s) begin
            oh = 4'b0001 << vecs[k].lane;
            check($sformatf("scen%0d_pos%0d", s, vecs[k].pos),
                  32'(log_rec[vecs[k].pos]), 32'({oh, oh, vecs[k].data}));
        end
    endtask

    task automatic add(input int s, input int l, input logic [7:0] d, input logic last, input int p);
        vec_t r;
        r.scen = s; r.lane = l; r.data = d; r.last = last; r.pos = p;
        vecs.push_back(r);
    endtask

    initial begin
        bit got;
        // scen 0: single requester, 3-byte message on lane 2
        add(0, 2, 8'h41, 1'b0, 0); add(0, 2, 8'h42, 1'b0, 1); add(0, 2, 8'h43, 1'b1, 2);
        // scen 1: lanes 0 and 3 contend with 2-byte messages
        add(1, 0, 8'h10, 1'b0, 0); add(1, 0, 8'h11, 1'b1, 1);
        add(1, 3, 8'h30, 1'b0, 2); add(1, 3, 8'h31, 1'b1, 3);
        // scen 2: pointer has wrapped to 0, so lane 0 beats lane 3 again
        add(2, 0, 8'h20, 1'b1, 0); add(2, 3, 8'h21, 1'b1, 1);
        // scen 3: fairness between continuously requesting lanes 0 and 1
        for (int m = 0; m < 4; m++) begin
            add(3, 0, 8'(8'h50 + m), 1'b1, 2*m);
            add(3, 1, 8'(8'h60 + m), 1'b1, 2*m + 1);
        end
        // scen 4: back-to-back messages from lane 0
        add(4, 0, 8'h70, 1'b0, 0); add(4, 0, 8'h71, 1'b1, 1); add(4, 0, 8'h72, 1'b1, 2);
        // scen 6: warm-up message from lane 0 before the reset test
        add(6, 0, 8'hE0, 1'b1, 0);
        // scen 5: after mid-message reset, pointer is back at 0
        add(5, 0, 8'hC0, 1'b1, 0); add(5, 1, 8'hC1, 1'b1, 1);

        do_reset();
        #1;
        check("reset_state", 32'({bus.grant, bus.req_ready, bus.tx_valid, bus.arb_idle, bus.tx_byte}),
              32'({4'b0000, 4'b0000, 1'b0, 1'b1, 8'h00}));

        run_scen(0, 1'b0);
        check("scen0_latency", 32'(first_tx - first_valid), 32'd17);
        check("scen0_ready_pulses_lane2", 32'(rdy_cnt[2]), 32'd3);
        check("scen0_grant_released", 32'(bus.grant), 32'd0);

        run_scen(1, 1'b1);
        run_scen(2, 1'b0);
        run_scen(3, 1'b1);
        run_scen(4, 1'b1);
        check("scen4_regrant_via_idle", 32'(idle_mid), 32'd1);
        check("scen4_gap_ok", 32'(min_gap >= GAP), 32'd1);

        // Reset while a launch is pending and uart_tx never goes busy.
        run_scen(6, 1'b1);
        clear_drivers();
        model_en = 1'b0;
        push_lane(1, 8'hB0, 1'b1);
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            step();
            got = bus.tx_valid;
        end
        check("launch_reached", 32'(got), 32'd1);
        check("launch_ready_lane1", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_drop", 32'({bus.tx_valid, bus.grant, bus.req_ready, bus.arb_idle}),
              32'({1'b0, 4'b0000, 4'b0000, 1'b1}));
        clear_drivers();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_en = 1'b1;
        #1;
        check("post_reset_idle", 32'(bus.arb_idle), 32'd1);
        run_scen(5, 1'b0);

        // Stall: lane 1 goes quiet after its first byte while lane 2 waits.
        do_reset();
        push_lane(1, 8'h80, 1'b0);
        push_lane(2, 8'h90, 1'b1);
        repeat (400) step();
        check("stall_first_byte", 32'(log_rec[0]), 32'({4'b0010, 4'b0010, 8'h80}));
`ifdef UART_TX_ARB_TIMEOUT_EN
        check("stall_timeout_pulse", 32'(to_cnt), 32'd1);
        check("stall_byte_count", 32'(n_log), 32'd2);
        check("stall_lane2_next", 32'(log_rec[1]), 32'({4'b0100, 4'b0100, 8'h90}));
`else
        check("stall_byte_count", 32'(n_log), 32'd1);
        check("stall_grant_held", 32'({bus.grant, bus.tx_valid}), 32'({4'b0010, 1'b0}));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
